// File: rtl/ad_arb_pkg.sv
// Shared types and constants for the round-robin frame arbiter.
package ad_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        READ = 2'd2,
        PAD  = 2'd3
    } arb_state_e;

    localparam logic [15:0] PAD_HDR = 16'hFADE;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ad_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_ch, wrapping.
module rr_pick
    import ad_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = ch_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] last_ch,
    output logic          valid,
    output logic [CW-1:0] idx
);
    logic [CW-1:0] start;
    logic [N-1:0]  rot;
    int            off;

    // Shifting the doubled vector puts channel last_ch+1 at bit 0; a shift of N is a no-op.
    assign start = last_ch + CW'(1);
    assign rot   = N'({req, req} >> start);

    always_comb begin
        valid = 1'b0;
        off   = 0;
        for (int p = N - 1; p >= 0; p--) begin
            if (rot[p]) begin
                valid = 1'b1;
                off   = p;
            end
        end
        idx = CW'((int'(last_ch) + 1 + off) % N);
    end

endmodule

// File: rtl/ad_frame_arbiter.sv
// Round-robin frame arbiter: moves one whole frame per grant from the channel FIFOs
// into the downstream FIFO, padding a frame whose channel stalls.
module ad_frame_arbiter
    import ad_arb_pkg::*;
#(
    parameter int  ADC_CHANEL  = 4,
    parameter int  FRAME_WORDS = 5186,
    parameter int  TIMEOUT     = 1024,
    localparam int CH_W        = ch_w(ADC_CHANEL)
) (
    input  logic                     clk_100m,
    input  logic                     reset,
    input  logic                     soft_path_rst,
    input  logic                     enable,
    input  logic [ADC_CHANEL-1:0]    ch_mask,
    input  logic [ADC_CHANEL-1:0]    fifo_empty,
    output logic [ADC_CHANEL-1:0]    fifo_rden,
    input  logic [32*ADC_CHANEL-1:0] data_in,
    input  logic                     out_afull,
    output logic                     out_wr_en,
    output logic [31:0]              out_din,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     busy,
    output logic [31:0]              frame_cnt,
    output logic [15:0]              pad_cnt
);
    localparam int              WL_W    = $clog2(FRAME_WORDS + 1);
    localparam int              ST_W    = $clog2(TIMEOUT + 1);
    localparam logic [WL_W-1:0] WL_FULL = WL_W'(FRAME_WORDS);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(TIMEOUT);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(TIMEOUT - 1);

    arb_state_e                       state_q, state_d;
    logic [CH_W-1:0]                  cur_ch_q, cur_ch_d, last_ch_q, last_ch_d;
    logic [WL_W-1:0]                  wl_q, wl_d;
    logic [ST_W-1:0]                  stall_q, stall_d;
    logic [31:0]                      frame_cnt_q, frame_cnt_d;
    logic [15:0]                      pad_cnt_q, pad_cnt_d;
    logic                             vld_p1_q, vld_p1_d, pad_p1_q, pad_p1_d;
    logic [CH_W-1:0]                  ch_p1_q, ch_p1_d;
    logic                             wr_en_p2_q, wr_en_p2_d;
    logic [31:0]                      dout_p2_q, dout_p2_d;
    logic                             rd_go, pad_go, last_word, done;
    logic                             pick_valid;
    logic [CH_W-1:0]                  pick_idx;
    logic [ADC_CHANEL-1:0][31:0]      din_w;

    assign din_w = data_in;

    rr_pick #(.N(ADC_CHANEL), .CW(CH_W)) u_pick (
        .req     (~ch_mask & ~fifo_empty),
        .last_ch (last_ch_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Soft reset also blocks the read strobe so no FIFO word is popped and then lost.
    assign last_word = (wl_q == WL_W'(1));
    assign rd_go  = (state_q == READ) && !fifo_empty[cur_ch_q] && !out_afull
                    && (wl_q != '0) && !soft_path_rst;
    assign pad_go = (state_q == PAD) && !out_afull && (wl_q != '0) && !soft_path_rst;

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        last_ch_d   = last_ch_q;
        wl_d        = wl_q;
        stall_d     = stall_q;
        frame_cnt_d = frame_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        done        = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = ARB;
            ARB: begin
                if (pick_valid) begin
                    cur_ch_d = pick_idx;
                    wl_d     = WL_FULL;
                    stall_d  = '0;
                    state_d  = READ;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_go) begin
                    wl_d    = wl_q - WL_W'(1);
                    stall_d = '0;
                    done    = last_word;
                end else if (fifo_empty[cur_ch_q] && !out_afull) begin
                    if (stall_q != ST_MAX) stall_d = stall_q + ST_W'(1);
                    if (stall_q >= ST_LAST) state_d = PAD;
                end
            end
            PAD: begin
                if (pad_go) begin
                    wl_d = wl_q - WL_W'(1);
                    if (pad_cnt_q != 16'hFFFF) pad_cnt_d = pad_cnt_q + 16'd1;
                    done = last_word;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done) begin
            last_ch_d   = cur_ch_q;
            frame_cnt_d = frame_cnt_q + 32'd1;
            state_d     = enable ? ARB : IDLE;
        end

        // Stage p1: read data arrives from the FIFO; stage p2: registered downstream write.
        vld_p1_d   = rd_go;
        pad_p1_d   = pad_go;
        ch_p1_d    = cur_ch_q;
        wr_en_p2_d = vld_p1_q || pad_p1_q;
        dout_p2_d  = dout_p2_q;
        if (vld_p1_q)      dout_p2_d = din_w[ch_p1_q];
        else if (pad_p1_q) dout_p2_d = {PAD_HDR, 12'h000, 4'(ch_p1_q)};

        if (soft_path_rst) begin
            state_d     = IDLE;
            cur_ch_d    = '0;
            last_ch_d   = CH_W'(ADC_CHANEL - 1);
            wl_d        = '0;
            stall_d     = '0;
            frame_cnt_d = '0;
            pad_cnt_d   = '0;
            vld_p1_d    = 1'b0;
            pad_p1_d    = 1'b0;
            ch_p1_d     = '0;
            wr_en_p2_d  = 1'b0;
            dout_p2_d   = '0;
        end
    end

    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            last_ch_q   <= CH_W'(ADC_CHANEL - 1);
            wl_q        <= '0;
            stall_q     <= '0;
            frame_cnt_q <= '0;
            pad_cnt_q   <= '0;
            vld_p1_q    <= 1'b0;
            pad_p1_q    <= 1'b0;
            ch_p1_q     <= '0;
            wr_en_p2_q  <= 1'b0;
            dout_p2_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            last_ch_q   <= last_ch_d;
            wl_q        <= wl_d;
            stall_q     <= stall_d;
            frame_cnt_q <= frame_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            vld_p1_q    <= vld_p1_d;
            pad_p1_q    <= pad_p1_d;
            ch_p1_q     <= ch_p1_d;
            wr_en_p2_q  <= wr_en_p2_d;
            dout_p2_q   <= dout_p2_d;
        end
    end

    assign fifo_rden = rd_go ? (ADC_CHANEL'(1) << cur_ch_q) : '0;
    assign out_wr_en = wr_en_p2_q;
    assign out_din   = dout_p2_q;
    assign cur_ch    = cur_ch_q;
    assign busy      = (state_q == READ) || (state_q == PAD);
    assign frame_cnt = frame_cnt_q;
    assign pad_cnt   = pad_cnt_q;

endmodule

// File: tb/tb_ad_frame_arbiter.sv
// Directed bench for ad_frame_arbiter with small frames and a short stall timeout.
`timescale 1ns/1ps
module tb_ad_frame_arbiter;
    localparam int NCH = 4;
    localparam int FW  = 8;
    localparam int TO  = 16;

    logic              clk_100m = 1'b0;
    logic              reset = 1'b1;
    logic              soft_path_rst = 1'b0;
    logic              enable = 1'b0;
    logic              out_afull = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH-1:0]    fifo_rden;
    logic [32*NCH-1:0] data_in = '0;
    logic              out_wr_en;
    logic [31:0]       out_din;
    logic [1:0]        cur_ch;
    logic              busy;
    logic [31:0]       frame_cnt;
    logic [15:0]       pad_cnt;

    int checks = 0;
    int errors = 0;

    // Channel FIFO models: written by the stimulus, popped on fifo_rden.
    logic [31:0] mem [NCH][256];
    int          wp  [NCH] = '{default: 0};
    int          rp  [NCH] = '{default: 0};
    int          seq [NCH] = '{default: 0};
    int          rd_cnt [NCH] = '{default: 0};
    int          cyc = 0;

    // Downstream capture.
    logic [31:0] cap_d [1024];
    int          cap_c [1024];
    int          cap_n = 0;
    int          viol = 0;
    logic        af_d1 = 1'b0;
    logic        af_d2 = 1'b0;

    always #5 clk_100m = ~clk_100m;

    for (genvar g = 0; g < NCH; g++) begin : g_emp
        assign fifo_empty[g] = (wp[g] == rp[g]);
    end

    always @(posedge clk_100m) begin
        cyc <= cyc + 1;
        for (int k = 0; k < NCH; k++) begin
            if (fifo_rden[k]) begin
                data_in[32*k +: 32] <= mem[k][8'(rp[k])];
                rp[k]     <= rp[k] + 1;
                rd_cnt[k] <= rd_cnt[k] + 1;
            end
        end
    end

    always @(negedge clk_100m) begin
        af_d1 <= out_afull;
        af_d2 <= af_d1;
        if (out_wr_en) begin
            if (af_d2) viol <= viol + 1;
            if (cap_n < 1024) begin
                cap_d[cap_n] <= out_din;
                cap_c[cap_n] <= cyc;
                cap_n        <= cap_n + 1;
            end
        end
    end

    ad_frame_arbiter #(.ADC_CHANEL(NCH), .FRAME_WORDS(FW), .TIMEOUT(TO)) dut (
        .clk_100m      (clk_100m),
        .reset         (reset),
        .soft_path_rst (soft_path_rst),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .fifo_empty    (fifo_empty),
        .fifo_rden     (fifo_rden),
        .data_in       (data_in),
        .out_afull     (out_afull),
        .out_wr_en     (out_wr_en),
        .out_din       (out_din),
        .cur_ch        (cur_ch),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .pad_cnt       (pad_cnt)
    );

    function automatic logic [31:0] wv(input int k, input int i);
        return 32'hA000_0000 | (32'(k) << 16) | 32'(i);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic push(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            mem[k][8'(wp[k])] = wv(k, seq[k]);
            seq[k]++;
            wp[k]++;
        end
    endtask

    task automatic restart();
        enable    = 1'b0;
        ch_mask   = '0;
        out_afull = 1'b0;
        tick(1);
        soft_path_rst = 1'b1;
        tick(1);
        soft_path_rst = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            wp[k]  = rp[k];
            seq[k] = 0;
        end
    endtask

    task automatic wait_frames(input logic [31:0] target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (fifo_rden !== '0) begin errors++; $display("FAIL reset_rden got %h want 0", fifo_rden); end
        checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", out_wr_en); end
        checks++; if (out_din !== 32'h0) begin errors++; $display("FAIL reset_din got %h want 0", out_din); end
        checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL reset_cur_ch got %0d want 0", cur_ch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        checks++; if (pad_cnt !== 16'd0) begin errors++; $display("FAIL reset_pad_cnt got %0d want 0", pad_cnt); end
        reset = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b0 || out_wr_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%b wr_en=%b want 0 0", busy, out_wr_en); end
    endtask

    task automatic test_round_robin();
        int base;
        restart();
        for (int k = 0; k < NCH; k++) push(k, FW);
        base = cap_n;
        enable = 1'b1;
        wait_frames(4, 200);
        tick(4);
        enable = 1'b0;
        tick(2);
        checks++; if (frame_cnt !== 32'd4) begin errors++; $display("FAIL rr_frame_cnt got %0d want 4", frame_cnt); end
        checks++; if (cap_n - base != 32) begin errors++; $display("FAIL rr_count got %0d want 32", cap_n - base); end
        for (int n = 0; n < 32; n++) begin
            checks++; if (cap_d[base+n] !== wv(n / FW, n % FW)) begin errors++; $display("FAIL rr_word[%0d] got %h want %h", n, cap_d[base+n], wv(n / FW, n % FW)); end
        end
        for (int n = 1; n < 32; n++) begin
            checks++;
            if (cap_c[base+n] - cap_c[base+n-1] != ((n % FW == 0) ? 2 : 1)) begin
                errors++; $display("FAIL rr_gap[%0d] got %0d want %0d", n, cap_c[base+n] - cap_c[base+n-1], (n % FW == 0) ? 2 : 1);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b want 0", busy); end
    endtask

    task automatic test_mask();
        int base, r0, r2, ch, idx;
        restart();
        ch_mask = 4'b0101;
        for (int k = 0; k < NCH; k++) push(k, 2 * FW);
        base = cap_n;
        r0 = rd_cnt[0];
        r2 = rd_cnt[2];
        enable = 1'b1;
        wait_frames(4, 300);
        tick(4);
        enable = 1'b0;
        tick(2);
        checks++; if (frame_cnt !== 32'd4) begin errors++; $display("FAIL mask_frame_cnt got %0d want 4", frame_cnt); end
        checks++; if (cap_n - base != 32) begin errors++; $display("FAIL mask_count got %0d want 32", cap_n - base); end
        for (int n = 0; n < 32; n++) begin
            ch  = ((n / FW) % 2 == 1) ? 3 : 1;
            idx = (n / (2 * FW)) * FW + n % FW;
            checks++; if (cap_d[base+n] !== wv(ch, idx)) begin errors++; $display("FAIL mask_word[%0d] got %h want %h", n, cap_d[base+n], wv(ch, idx)); end
        end
        checks++; if (rd_cnt[0] != r0) begin errors++; $display("FAIL mask_rden0 got %0d reads want 0", rd_cnt[0] - r0); end
        checks++; if (rd_cnt[2] != r2) begin errors++; $display("FAIL mask_rden2 got %0d reads want 0", rd_cnt[2] - r2); end
    endtask

    task automatic test_afull();
        int base, v0;
        logic [39:0] pat;
        pat = 40'hD3A56C9BE1;
        restart();
        push(0, FW);
        base = cap_n;
        v0 = viol;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_afull = pat[i];
            tick(1);
        end
        out_afull = 1'b0;
        wait_frames(1, 100);
        tick(4);
        enable = 1'b0;
        tick(2);
        checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL afull_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (cap_n - base != FW) begin errors++; $display("FAIL afull_count got %0d want %0d", cap_n - base, FW); end
        for (int n = 0; n < FW; n++) begin
            checks++; if (cap_d[base+n] !== wv(0, n)) begin errors++; $display("FAIL afull_word[%0d] got %h want %h", n, cap_d[base+n], wv(0, n)); end
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL afull_late_write got %0d want 0", viol - v0); end
    endtask

    task automatic test_pad();
        int base;
        logic [31:0] exp;
        restart();
        ch_mask = 4'b0011;
        push(2, 3);
        push(3, FW);
        base = cap_n;
        enable = 1'b1;
        wait_frames(2, 300);
        tick(4);
        enable = 1'b0;
        tick(2);
        checks++; if (frame_cnt !== 32'd2) begin errors++; $display("FAIL pad_frame_cnt got %0d want 2", frame_cnt); end
        checks++; if (pad_cnt !== 16'd5) begin errors++; $display("FAIL pad_cnt got %0d want 5", pad_cnt); end
        checks++; if (cap_n - base != 2 * FW) begin errors++; $display("FAIL pad_count got %0d want %0d", cap_n - base, 2 * FW); end
        for (int n = 0; n < 2 * FW; n++) begin
            exp = (n < 3) ? wv(2, n) : (n < FW) ? 32'hFADE0002 : wv(3, n - FW);
            checks++; if (cap_d[base+n] !== exp) begin errors++; $display("FAIL pad_word[%0d] got %h want %h", n, cap_d[base+n], exp); end
        end
        checks++; if (cap_c[base+3] - cap_c[base+2] != TO + 1) begin errors++; $display("FAIL pad_stall_gap got %0d want %0d", cap_c[base+3] - cap_c[base+2], TO + 1); end
    endtask

    task automatic test_enable_drop();
        int base, r1, r2, n;
        restart();
        ch_mask = 4'b1001;
        push(1, FW);
        push(2, FW);
        base = cap_n;
        r1 = rd_cnt[1];
        r2 = rd_cnt[2];
        enable = 1'b1;
        n = 0;
        while (rd_cnt[1] - r1 < 4 && n < 50) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        tick(20);
        checks++; if (frame_cnt !== 32'd1) begin errors++; $display("FAIL drop_frame_cnt got %0d want 1", frame_cnt); end
        checks++; if (cap_n - base != FW) begin errors++; $display("FAIL drop_count got %0d want %0d", cap_n - base, FW); end
        for (int i = 0; i < FW; i++) begin
            checks++; if (cap_d[base+i] !== wv(1, i)) begin errors++; $display("FAIL drop_word[%0d] got %h want %h", i, cap_d[base+i], wv(1, i)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
        checks++; if (rd_cnt[2] != r2) begin errors++; $display("FAIL drop_rden2 got %0d reads want 0", rd_cnt[2] - r2); end
        checks++; if (fifo_rden !== '0) begin errors++; $display("FAIL drop_rden got %h want 0", fifo_rden); end
    endtask

    task automatic test_soft_reset();
        int r0, n, c0, rs;
        restart();
        push(0, FW);
        r0 = rd_cnt[0];
        enable = 1'b1;
        n = 0;
        while (rd_cnt[0] - r0 < 4 && n < 50) begin
            tick(1);
            n++;
        end
        soft_path_rst = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL soft_busy got %b want 0", busy); end
        checks++; if (fifo_rden !== '0) begin errors++; $display("FAIL soft_rden got %h want 0", fifo_rden); end
        checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL soft_wr_en got %b want 0", out_wr_en); end
        checks++; if (out_din !== 32'h0) begin errors++; $display("FAIL soft_din got %h want 0", out_din); end
        checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL soft_cur_ch got %0d want 0", cur_ch); end
        checks++; if (frame_cnt !== 32'd0) begin errors++; $display("FAIL soft_frame_cnt got %0d want 0", frame_cnt); end
        c0 = cap_n;
        rs = rd_cnt[0];
        soft_path_rst = 1'b0;
        enable = 1'b0;
        tick(10);
        checks++; if (cap_n != c0) begin errors++; $display("FAIL soft_inflight got %0d writes want 0", cap_n - c0); end
        checks++; if (rd_cnt[0] != rs) begin errors++; $display("FAIL soft_reads got %0d reads want 0", rd_cnt[0] - rs); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_mask();
        test_afull();
        test_pad();
        test_enable_drop();
        test_soft_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
